// File: rtl/tlc_pkg.sv
// Shared types and helpers for the traffic phase controller family.
//   phase_t    : controller phase encoding (2-bit)
//   lamp_t     : per-approach lamp triple {red, yellow, green}
//   cnt_width  : phase timer width that holds the largest phase time
package tlc_pkg;

   typedef enum logic [1:0] {
      PH_GREEN  = 2'd0,
      PH_YELLOW = 2'd1,
      PH_ALLRED = 2'd2
   } phase_t;

   typedef logic [2:0] lamp_t;

   localparam lamp_t LAMP_RED    = 3'b100;
   localparam lamp_t LAMP_YELLOW = 3'b010;
   localparam lamp_t LAMP_GREEN  = 3'b001;

   function automatic int unsigned cnt_width(input int unsigned a, input int unsigned b,
                                             input int unsigned c, input int unsigned d);
      int unsigned m;
      m = a;
      if (b > m) m = b;
      if (c > m) m = c;
      if (d > m) m = d;
      return ($clog2(m + 1) < 1) ? 1 : $clog2(m + 1);
   endfunction

endpackage

// File: rtl/rr_next_dir.sv
// Combinational round-robin picker.
//   req : per-approach request vector
//   cur : approach currently served (excluded from the scan)
//   nxt : first requesting approach after cur, scanning cur+1, cur+2, ...
//         modulo NUM_DIR; cur+1 (mod NUM_DIR) when nobody requests
module rr_next_dir #(
   parameter int unsigned NUM_DIR = 4
) (
   input  logic [NUM_DIR-1:0]         req,
   input  logic [$clog2(NUM_DIR)-1:0] cur,
   output logic [$clog2(NUM_DIR)-1:0] nxt
);
   import tlc_pkg::*;

   localparam int unsigned DIR_W = $clog2(NUM_DIR);

   always_comb begin
      int unsigned idx;
      idx = 32'(cur) + 1;
      if (idx >= NUM_DIR) idx = idx - NUM_DIR;
      nxt = DIR_W'(idx);
      // Scan farthest-first so the nearest requester overwrites the result last.
      for (int unsigned i = NUM_DIR - 1; i >= 1; i--) begin
         idx = 32'(cur) + i;
         if (idx >= NUM_DIR) idx = idx - NUM_DIR;
         if (req[DIR_W'(idx)]) nxt = DIR_W'(idx);
      end
   end

endmodule

// File: rtl/traffic_phase_controller.sv
// N-approach traffic-light sequencer with timed green/yellow phases and
// demand-driven round-robin hand-over.
//   clk     : clock
//   rst     : synchronous active-high reset
//   sense   : per-approach vehicle demand (already synchronous)
//   red     : red lamp per approach
//   yellow  : yellow lamp per approach
//   green   : green lamp per approach
//   cur_dir : approach currently served
// Build option: define ALL_RED_EN to insert an all-red clearance phase
// between yellow and the next green.
module traffic_phase_controller #(
   parameter int unsigned NUM_DIR      = 4,
   parameter int unsigned GREEN_MIN    = 4,
   parameter int unsigned GREEN_MAX    = 10,
   parameter int unsigned YELLOW_TIME  = 2,
   parameter int unsigned ALL_RED_TIME = 1
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic [NUM_DIR-1:0]         sense,
   output logic [NUM_DIR-1:0]         red,
   output logic [NUM_DIR-1:0]         yellow,
   output logic [NUM_DIR-1:0]         green,
   output logic [$clog2(NUM_DIR)-1:0] cur_dir
);
   import tlc_pkg::*;

   localparam int unsigned DIR_W = $clog2(NUM_DIR);
   localparam int unsigned CNT_W = cnt_width(GREEN_MIN, GREEN_MAX, YELLOW_TIME, ALL_RED_TIME);

   localparam logic [CNT_W-1:0] G_MIN_T = CNT_W'(GREEN_MIN - 1);
   localparam logic [CNT_W-1:0] G_MAX_T = CNT_W'(GREEN_MAX - 1);
   localparam logic [CNT_W-1:0] Y_T     = CNT_W'(YELLOW_TIME - 1);
   localparam logic [CNT_W-1:0] AR_T    = CNT_W'(ALL_RED_TIME - 1);

   phase_t             phase;
   logic [CNT_W-1:0]   timer;
   logic [DIR_W-1:0]   nxt_dir;
   logic [DIR_W-1:0]   pick;
   logic [NUM_DIR-1:0] cur_oh;
   logic               other_req;

   assign cur_oh    = NUM_DIR'(1) << cur_dir;
   assign other_req = |(sense & ~cur_oh);

   rr_next_dir #(.NUM_DIR(NUM_DIR)) u_pick (
      .req (sense),
      .cur (cur_dir),
      .nxt (pick)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         phase   <= PH_GREEN;
         cur_dir <= '0;
         timer   <= '0;
         nxt_dir <= '0;
      end else begin
         case (phase)
            PH_GREEN: begin
               if (other_req && (timer == G_MAX_T || (timer >= G_MIN_T && !sense[cur_dir]))) begin
                  phase <= PH_YELLOW;
                  timer <= '0;
               end else if (timer < G_MAX_T) begin
                  timer <= timer + 1'b1;
               end
            end
            PH_YELLOW: begin
               if (timer == Y_T) begin
                  timer   <= '0;
                  nxt_dir <= pick;
`ifdef ALL_RED_EN
                  phase   <= PH_ALLRED;
`else
                  phase   <= PH_GREEN;
                  cur_dir <= pick;
`endif
               end else begin
                  timer <= timer + 1'b1;
               end
            end
            PH_ALLRED: begin
               // cur_dir stays on the old approach here; the grant latched at
               // yellow exit takes effect only when green starts.
               if (timer == AR_T) begin
                  phase   <= PH_GREEN;
                  cur_dir <= nxt_dir;
                  timer   <= '0;
               end else begin
                  timer <= timer + 1'b1;
               end
            end
            default: begin
               phase <= PH_GREEN;
               timer <= '0;
            end
         endcase
      end
   end

   always_comb begin
      lamp_t lamp;
      red    = '0;
      yellow = '0;
      green  = '0;
      for (int unsigned i = 0; i < NUM_DIR; i++) begin
         lamp = LAMP_RED;
         if (DIR_W'(i) == cur_dir) begin
            case (phase)
               PH_GREEN:  lamp = LAMP_GREEN;
               PH_YELLOW: lamp = LAMP_YELLOW;
               default:   lamp = LAMP_RED;
            endcase
         end
         red[i]    = lamp[2];
         yellow[i] = lamp[1];
         green[i]  = lamp[0];
      end
   end

endmodule

// File: tb/tb_traffic_phase_controller.sv
module tb_traffic_phase_controller;

   localparam int K_G = 0;
   localparam int K_Y = 1;
   localparam int K_R = 2;

   logic       clk;
   logic       rst;
   logic [3:0] sense;
   logic [3:0] red;
   logic [3:0] yellow;
   logic [3:0] green;
   logic [1:0] cur_dir;

   int npass;
   int ntotal;

   typedef struct {
      logic       rst;
      logic [3:0] sense;
      int         cnt;
      logic [3:0] g;
      logic [3:0] y;
      logic [3:0] r;
      logic [1:0] dir;
   } vec_t;

   vec_t tbl[$];

   traffic_phase_controller #(
      .NUM_DIR(4),
      .GREEN_MIN(4),
      .GREEN_MAX(10),
      .YELLOW_TIME(2),
      .ALL_RED_TIME(1)
   ) dut (
      .clk(clk),
      .rst(rst),
      .sense(sense),
      .red(red),
      .yellow(yellow),
      .green(green),
      .cur_dir(cur_dir)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic vec_t mk(input logic r_in, input logic [3:0] s, input int cnt,
                               input int kind, input logic [1:0] dir);
      vec_t v;
      logic [3:0] one;
      one     = 4'b0001 << dir;
      v.rst   = r_in;
      v.sense = s;
      v.cnt   = cnt;
      v.dir   = dir;
      v.g     = (kind == K_G) ? one : 4'b0000;
      v.y     = (kind == K_Y) ? one : 4'b0000;
      v.r     = (kind == K_R) ? 4'b1111 : ~one;
      return v;
   endfunction

   task automatic row(input logic r_in, input logic [3:0] s, input int cnt,
                      input int kind, input logic [1:0] dir);
      tbl.push_back(mk(r_in, s, cnt, kind, dir));
   endtask

   // All-red clearance cycle, present only in the ALL_RED_EN build.
   task automatic ar(input logic [3:0] s, input logic [1:0] dir);
`ifdef ALL_RED_EN
      tbl.push_back(mk(1'b0, s, 1, K_R, dir));
`else
      if (s === 4'bxxxx && dir === 2'bxx) tbl.push_back(mk(1'b0, s, 1, K_R, dir));
`endif
   endtask

   task automatic chk(input string name, input logic [3:0] act, input logic [3:0] exp, input int cyc);
      ntotal++;
      if (act === exp) npass++;
      else $display("FAIL %s cycle %0d: got %b expected %b", name, cyc, act, exp);
   endtask

   task automatic apply(input vec_t v, inout int cyc);
      for (int n = 0; n < v.cnt; n++) begin
         @(negedge clk);
         rst   = v.rst;
         sense = v.sense;
         @(posedge clk);
         #1;
         cyc++;
         chk("green",   green,          v.g,          cyc);
         chk("yellow",  yellow,         v.y,          cyc);
         chk("red",     red,            v.r,          cyc);
         chk("cur_dir", {2'b00, cur_dir}, {2'b00, v.dir}, cyc);
      end
   endtask

   initial begin
      int cyc;
      vec_t v;
      npass  = 0;
      ntotal = 0;
      cyc    = 0;
      rst    = 1'b1;
      sense  = 4'b0000;

      // Idle: green stays on approach 0 with no demand.
      row(1, 4'b0000, 2,  K_G, 0);
      row(0, 4'b0000, 50, K_G, 0);
      // Single competing request: minimum green, yellow, then hold on 2.
      row(1, 4'b0100, 1,  K_G, 0);
      row(0, 4'b0100, 3,  K_G, 0);
      row(0, 4'b0100, 2,  K_Y, 0);
      ar(4'b0100, 0);
      row(0, 4'b0100, 20, K_G, 2);
      // Reset in the first yellow cycle of approach 2, then verify timer restarted.
      row(0, 4'b0001, 1,  K_Y, 2);
      row(1, 4'b0001, 1,  K_G, 0);
      row(0, 4'b0100, 3,  K_G, 0);
      row(0, 4'b0100, 2,  K_Y, 0);
      ar(4'b0100, 0);
      row(0, 4'b0100, 2,  K_G, 2);
      // Demand withdrawn during yellow: hand-over defaults to cur_dir+1.
      row(1, 4'b0100, 1,  K_G, 0);
      row(0, 4'b0100, 3,  K_G, 0);
      row(0, 4'b0100, 1,  K_Y, 0);
      row(0, 4'b0000, 1,  K_Y, 0);
      ar(4'b0000, 0);
      row(0, 4'b0000, 5,  K_G, 1);
      // Two persistent requests: maximum green alternating 0 and 1.
      row(1, 4'b0011, 1,  K_G, 0);
      row(0, 4'b0011, 9,  K_G, 0);
      row(0, 4'b0011, 2,  K_Y, 0);
      ar(4'b0011, 0);
      row(0, 4'b0011, 10, K_G, 1);
      row(0, 4'b0011, 2,  K_Y, 1);
      ar(4'b0011, 1);
      row(0, 4'b0011, 10, K_G, 0);
      row(0, 4'b0011, 2,  K_Y, 0);
      // Wrap from approach 3 to 0, then 0 to 2.
      row(1, 4'b1000, 1,  K_G, 0);
      row(0, 4'b1000, 3,  K_G, 0);
      row(0, 4'b1000, 2,  K_Y, 0);
      ar(4'b1000, 0);
      row(0, 4'b1000, 1,  K_G, 3);
      row(0, 4'b0101, 3,  K_G, 3);
      row(0, 4'b0101, 2,  K_Y, 3);
      ar(4'b0101, 3);
      row(0, 4'b0101, 10, K_G, 0);
      row(0, 4'b0101, 2,  K_Y, 0);
      ar(4'b0101, 0);
      row(0, 4'b0101, 3,  K_G, 2);
      // From approach 1 with requests on 0 and 2: nearest (2) wins.
      row(1, 4'b0010, 1,  K_G, 0);
      row(0, 4'b0010, 3,  K_G, 0);
      row(0, 4'b0010, 2,  K_Y, 0);
      ar(4'b0010, 0);
      row(0, 4'b0010, 1,  K_G, 1);
      row(0, 4'b0101, 3,  K_G, 1);
      row(0, 4'b0101, 2,  K_Y, 1);
      ar(4'b0101, 1);
      row(0, 4'b0101, 3,  K_G, 2);

      foreach (tbl[i]) apply(tbl[i], cyc);

      // Everyone requesting: full rotation 0,1,2,3,0 at maximum green.
      v = mk(1'b1, 4'b1111, 1, K_G, 0);
      apply(v, cyc);
      v = mk(1'b0, 4'b1111, 9, K_G, 0);
      apply(v, cyc);
      for (int k = 0; k < 4; k++) begin
         v = mk(1'b0, 4'b1111, 2, K_Y, 2'(k));
         apply(v, cyc);
`ifdef ALL_RED_EN
         v = mk(1'b0, 4'b1111, 1, K_R, 2'(k));
         apply(v, cyc);
`endif
         v = mk(1'b0, 4'b1111, 10, K_G, 2'((k + 1) % 4));
         apply(v, cyc);
      end

      $display("%0d/%0d checks passed", npass, ntotal);
      $finish;
   end

endmodule
